// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - four-digit multiplexed seven-segment scan driver with frame-atomic updates
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        value_we,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        pending
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   disp_q, disp_d;
  logic          pend_q, pend_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          tick;
  logic          wrap;
  logic [3:0]    nib;
  logic          lz1, lz2, lz3;
  logic          blank;

  // Active-low gfedcba glyph for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  assign tick = (cnt_q == CNT_LAST);
  assign wrap = tick && (idx_q == 2'd3);

  // A digit is a leading zero when it and every digit above it are zero.
  assign lz3 = (disp_q[15:12] == 4'h0);
  assign lz2 = lz3 && (disp_q[11:8] == 4'h0);
  assign lz1 = lz2 && (disp_q[7:4] == 4'h0);

  // Select the nibble and blanking decision for the digit slot currently scanned.
  always_comb begin
    nib   = disp_q[3:0];
    blank = 1'b0;
    case (idx_q)
      2'd0: begin
        nib   = disp_q[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        nib   = disp_q[7:4];
        blank = blank_lz && lz1;
      end
      2'd2: begin
        nib   = disp_q[11:8];
        blank = blank_lz && lz2;
      end
      default: begin
        nib   = disp_q[15:12];
        blank = blank_lz && lz3;
      end
    endcase
  end

  // Next-state: refresh timing, shadow capture, and display swap only at the frame boundary.
  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    shadow_d = value_we ? value_in : shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    if (wrap) begin
      // A write landing on the wrap edge goes straight to the display.
      if (value_we) begin
        disp_d = value_in;
      end else if (pend_q) begin
        disp_d = shadow_q;
      end
      pend_d = 1'b0;
    end else if (value_we) begin
      pend_d = 1'b1;
    end
    an_d  = blank ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = blank ? 7'h7F : decode(nib);
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      disp_q   <= 16'h0000;
      pend_q   <= 1'b0;
      an_q     <= 4'hF;
      seg_q    <= 7'h7F;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver with REFRESH_DIV=4
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic        value_we;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        pending;

  int total;
  int bad;

  logic [10:0] sb_q[$];

  logic [15:0] exp_disp;
  logic [15:0] exp_shadow;
  logic        exp_pend;

  seg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .value_in (value_in),
    .value_we (value_we),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // Expected {an, seg} for one digit slot of a frame showing d.
  function automatic logic [10:0] slot_out(input logic [15:0] d, input int k, input bit blk);
    logic [15:0] upper;
    logic [3:0]  n;
    upper = d >> (4 * k);
    n     = upper[3:0];
    if (blk && k != 0 && upper == 16'h0000)
      slot_out = {4'hF, 7'h7F};
    else
      slot_out = {4'(~(4'b0001 << k)), glyph(n)};
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One 16-cycle frame: queue its expected outputs, run it with up to two writes, compare as it scans.
  task automatic frame(input bit blk, input int w1_at, input logic [15:0] w1_v,
                       input int w2_at, input logic [15:0] w2_v);
    logic [10:0] got;
    logic [10:0] want;
    blank_lz = blk;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 4; c++)
        sb_q.push_back(slot_out(exp_disp, s, blk));
    for (int i = 0; i < 16; i++) begin
      value_we = (i == w1_at) || (i == w2_at);
      value_in = (i == w1_at) ? w1_v : ((i == w2_at) ? w2_v : 16'h0000);
      step();
      if (i == 15) begin
        if (value_we) begin
          exp_disp   = value_in;
          exp_shadow = value_in;
        end else if (exp_pend) begin
          exp_disp = exp_shadow;
        end
        exp_pend = 1'b0;
      end else if (value_we) begin
        exp_shadow = value_in;
        exp_pend   = 1'b1;
      end
      value_we = 1'b0;
      got = {an, seg};
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", 16'd0, 16'd1);
      end else begin
        want = sb_q.pop_front();
        check("an_seg", {5'd0, got}, {5'd0, want});
      end
      check("pending", {15'd0, pending}, {15'd0, exp_pend});
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    value_in   = 16'h0000;
    value_we   = 1'b0;
    blank_lz   = 1'b0;
    exp_disp   = 16'h0000;
    exp_shadow = 16'h0000;
    exp_pend   = 1'b0;

    step();
    step();
    check("reset_an", {12'd0, an}, 16'h000F);
    check("reset_seg", {9'd0, seg}, 16'h007F);
    check("reset_pending", {15'd0, pending}, 16'h0000);

    rst = 1'b1;
    frame(1'b0, -1, 16'h0000, -1, 16'h0000);
    frame(1'b0, 5, 16'h12AF, -1, 16'h0000);
    frame(1'b0, -1, 16'h0000, -1, 16'h0000);
    frame(1'b1, 3, 16'h0005, -1, 16'h0000);
    frame(1'b1, -1, 16'h0000, -1, 16'h0000);
    frame(1'b0, 2, 16'h1111, 9, 16'h2222);
    frame(1'b0, 15, 16'hBEEF, -1, 16'h0000);
    frame(1'b0, -1, 16'h0000, -1, 16'h0000);

    value_in = 16'h7777;
    value_we = 1'b1;
    step();
    value_we = 1'b0;
    check("mid_pending_set", {15'd0, pending}, 16'h0001);
    step();
    step();
    rst = 1'b0;
    step();
    check("midrst_an", {12'd0, an}, 16'h000F);
    check("midrst_seg", {9'd0, seg}, 16'h007F);
    check("midrst_pending", {15'd0, pending}, 16'h0000);
    value_in = 16'h3333;
    value_we = 1'b1;
    step();
    check("we_in_reset_pending", {15'd0, pending}, 16'h0000);
    value_we   = 1'b0;
    rst        = 1'b1;
    exp_disp   = 16'h0000;
    exp_shadow = 16'h0000;
    exp_pend   = 1'b0;
    frame(1'b1, -1, 16'h0000, -1, 16'h0000);
    frame(1'b0, -1, 16'h0000, -1, 16'h0000);

    check("scoreboard_drained", 16'(sb_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
